io_seg_scan: RTL and testbench
==============================

# io_seg_scan

Time-multiplexed scan controller for the eight-digit seven-segment display on the single-cycle computer's I/O side. It sits downstream of the CPU output-port decode. It latches a 32-bit value written by the CPU and drives the two segment buses plus digit selects that leave the chip as `seg_data_0_pin`, `seg_data_1_pin` and `seg_cs_pin`. Each nibble is shown as one hex digit, with optional leading-zero blanking, per-digit decimal points, and a ghost-suppression blank gap between digits.

## Interface
- `SCAN_DIV`, default 100000: clocks per scan phase, so 1 kHz phase rate at 100 MHz. Must be ≥ 4.
- `BLANK_CYC`, default 16: clocks at the start of each phase during which all selects are off. Must be < `SCAN_DIV`.
- `sys_clk_in`  in  1  system clock; all logic on the rising edge.
- `sys_rst_n`  in  1  synchronous, active-low reset.
- `wr_en`  in  1  one-cycle write strobe from the CPU I/O decode.
- `wr_data`  in  32  display value; nibble k is digit k, and digit 0 is the rightmost.
- `dp_mask`  in  8  decimal-point enable per digit; sampled together with `wr_data`.
- `lz_en`  in  1  leading-zero blanking enable; sampled together with `wr_data`.
- `seg_cs_pin`  out  8  digit selects, active high, one-hot per group.
- `seg_data_0_pin`  out  [0:7]  segments A,B,C,D,E,F,G,DP for digits 0–3, active high.
- `seg_data_1_pin`  out  [0:7]  segments for digits 4–7, same encoding.

## Operation
- **Shadow register.**
  - `wr_en` = 1 loads `wr_data`, `dp_mask` and `lz_en` into the shadow set at the same edge.
  - With several writes in one frame, the last one wins.
- **Active register.**
  - Copied from the shadow set only at a frame boundary, i.e. at the edge where the phase wraps from 3 to 0.
  - A frame is never torn: all 8 digits of one frame come from one value.
- **Scan.**
  - A 2-bit phase p runs 0→1→2→3→0.
  - In phase p, group 0 shows digit p on `seg_data_0_pin` with `seg_cs_pin[p]`.
  - Group 1 shows digit p+4 on `seg_data_1_pin` with `seg_cs_pin[p+4]`.
  - Exactly two select bits are high outside the blank gap.
- **Divider.**
  - Counter `div_cnt` runs 0..`SCAN_DIV`-1.
  - At `SCAN_DIV`-1 it wraps to 0 and the phase advances.
- **Blank gap.**
  - While `div_cnt` < `BLANK_CYC`, `seg_cs_pin` = 0.
  - During the gap the segment buses already carry the new phase's patterns.
- **Decode.**
  - Hex 0–F map to standard A–G patterns, with lowercase b and d.
  - Examples (bits A..G): 0 → 1111110, 1 → 0110000, 8 → 1111111, F → 1000111.
  - DP bit = `dp_mask[k]`.
- **Leading-zero blank.**
  - When `lz_en` = 1, every digit above the most significant non-zero nibble has A–G = 0.
  - Its DP is still driven from `dp_mask`.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- **Reset** (`sys_rst_n` = 0 at an edge):
  - Shadow and active registers cleared (value 0, `dp_mask` 0, `lz_en` 0).
  - `div_cnt` = 0 and phase = 0.
  - All outputs 0.
  - A write in the same cycle as reset is dropped.
- **Simultaneous events.**
  - A write at the frame-boundary edge goes to the shadow set.
  - The active register takes the old shadow contents.
  - The new value is displayed from the following frame.

## Timing
- All outputs are registered.
- Outputs reflect the counter and phase state one clock after the state changes.
- After reset release, the first non-zero `seg_cs_pin` appears `BLANK_CYC`+1 clocks later (phase 0: bits 0 and 4).
- Write to display latency:
  - The value reaches the active register at the next frame boundary, at most 4·`SCAN_DIV` clocks after `wr_en`.
  - It is visible on the pins one clock later.
- Frame period = 4·`SCAN_DIV` clocks; per-digit duty = (`SCAN_DIV`−`BLANK_CYC`)/(4·`SCAN_DIV`).

## Structure
- Shared package `io_pkg` holds:
  - the 7-bit hex-to-segment constant table, as function `hex2seg`;
  - segment bit-index constants (`SEG_A`..`SEG_DP`);
  - the digit count (8) and group size (4).
- One sub-module, `seg_digit_enc`:
  - inputs: nibble, blank flag, dp; output: 8-bit [0:7] segment vector;
  - instantiated twice, once per group.
- The leading-zero blank vector is computed combinationally from the active register, in the top level.

## Test plan
Bench uses `SCAN_DIV` = 8 and `BLANK_CYC` = 2.

1. **Reset.** Hold `sys_rst_n` = 0 for 3 clocks, with `wr_en` = 1 during reset → all outputs 0. After release, `seg_cs_pin` = 0 for 3 clocks, then 8'b0001_0001 and both buses = "0" pattern 11111100.
2. **Basic write.**
   - Write 32'h1234_ABCD, `dp_mask` 0, `lz_en` 0, during phase 2 → the display updates only after the phase 3→0 wrap.
   - Phase 0: `seg_data_0_pin` = d (0111101,DP0), `seg_data_1_pin` = 4 (0110011,DP0).
   - Phase 3: group 0 shows A, group 1 shows 1.
3. **Scan order and gap.**
   - Over one frame, `seg_cs_pin` sequence is 8'h11, 8'h22, 8'h44, 8'h88, each held 6 clocks.
   - Each is preceded by 2 clocks of 8'h00.
4. **Leading zero.**
   - Write 32'h0000_0050 with `lz_en` = 1 → digits 7..2 have A–G = 0; digit 1 shows 5; digit 0 shows 0.
   - Write 0 with `lz_en` = 1 → only digit 0 lit.
5. **DP and last write wins.**
   - Two writes in one frame: 32'hFFFF_FFFF then 32'h8888_8888 with `dp_mask` 8'h81.
   - Next frame shows all 8s; DP = 1 only on digits 0 and 7.
6. **Reset mid-frame.** Assert reset during phase 2 with a non-zero display → next edge all outputs 0, the shadow set is cleared, and the scan restarts at phase 0.

Source files
------------

// File: rtl/io_pkg.sv
// Shared constants and the hex-to-segment table for the seven-segment scan path.
package io_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int GROUP_SIZE = 4;

  // Bit positions inside a [0:7] segment vector (A first, DP last).
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;

  typedef logic [0:7] seg_vec_t;

  // Hex nibble to A..G pattern, element 0 is segment A. Lowercase b and d.
  function automatic logic [0:6] hex2seg(input logic [3:0] nib);
    logic [0:6] pat;
    case (nib)
      4'h0: pat = 7'b1111110;
      4'h1: pat = 7'b0110000;
      4'h2: pat = 7'b1101101;
      4'h3: pat = 7'b1111001;
      4'h4: pat = 7'b0110011;
      4'h5: pat = 7'b1011011;
      4'h6: pat = 7'b1011111;
      4'h7: pat = 7'b1110000;
      4'h8: pat = 7'b1111111;
      4'h9: pat = 7'b1111011;
      4'hA: pat = 7'b1110111;
      4'hB: pat = 7'b0011111;
      4'hC: pat = 7'b1001110;
      4'hD: pat = 7'b0111101;
      4'hE: pat = 7'b1001111;
      default: pat = 7'b1000111;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg_digit_enc.sv
// One digit encoder: nibble to A..G pattern, forced dark when blanked, DP passed through.
module seg_digit_enc
  import io_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output seg_vec_t   seg
);

  // Blanking only darkens A..G; the decimal point always follows dp.
  always_comb begin
    seg              = '0;
    seg[SEG_A:SEG_G] = blank ? 7'b0000000 : hex2seg(nibble);
    seg[SEG_DP]      = dp;
  end

endmodule

// File: rtl/io_seg_scan.sv
// Eight-digit seven-segment scan controller: shadow/active value registers,
// phase divider with a blank gap, two-group digit multiplexing, registered pins.
module io_seg_scan
  import io_pkg::*;
#(
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic        sys_clk_in,
  input  logic        sys_rst_n,
  input  logic        wr_en,
  input  logic [31:0] wr_data,
  input  logic [7:0]  dp_mask,
  input  logic        lz_en,
  output logic [7:0]  seg_cs_pin,
  output logic [0:7]  seg_data_0_pin,
  output logic [0:7]  seg_data_1_pin
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] BLANK_END = DIV_W'(BLANK_CYC);

  // Scan phase encoding: phase p drives digit p and digit p+4.
  localparam logic [1:0] PHASE_0    = 2'd0;
  localparam logic [1:0] PHASE_LAST = 2'd3;

  logic [31:0]      sh_val_q, sh_val_d;
  logic [7:0]       sh_dp_q, sh_dp_d;
  logic             sh_lz_q, sh_lz_d;
  logic [31:0]      act_val_q, act_val_d;
  logic [7:0]       act_dp_q, act_dp_d;
  logic             act_lz_q, act_lz_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       phase_q, phase_d;
  logic [7:0]       cs_q, cs_d;
  seg_vec_t         seg0_q, seg0_d;
  seg_vec_t         seg1_q, seg1_d;

  logic             div_wrap;
  logic             frame_wrap;
  logic [NUM_DIGITS-1:0] lz_blank;
  logic             upper_zero;
  logic [2:0]       dig0_idx;
  logic [2:0]       dig1_idx;
  logic [3:0]       nib0;
  logic [3:0]       nib1;
  seg_vec_t         seg0_w;
  seg_vec_t         seg1_w;

  // Divider, phase, and shadow/active register next-state.
  always_comb begin
    div_wrap   = (div_cnt_q == DIV_LAST);
    frame_wrap = div_wrap && (phase_q == PHASE_LAST);
    div_cnt_d  = div_wrap ? '0 : div_cnt_q + 1'b1;
    phase_d    = div_wrap ? phase_q + 2'd1 : phase_q;
    // A write at the frame edge lands in the shadow; active takes the old shadow.
    sh_val_d   = wr_en ? wr_data : sh_val_q;
    sh_dp_d    = wr_en ? dp_mask : sh_dp_q;
    sh_lz_d    = wr_en ? lz_en   : sh_lz_q;
    act_val_d  = frame_wrap ? sh_val_q : act_val_q;
    act_dp_d   = frame_wrap ? sh_dp_q  : act_dp_q;
    act_lz_d   = frame_wrap ? sh_lz_q  : act_lz_q;
  end

  // Leading-zero blank: a digit is dark when it and every digit above it are zero.
  // Digit 0 is never blanked so a zero value still shows "0".
  always_comb begin
    lz_blank   = '0;
    upper_zero = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      upper_zero  = upper_zero & (act_val_q[4*k +: 4] == 4'h0);
      lz_blank[k] = act_lz_q & upper_zero;
    end
  end

  // Current digit of each group, selected by phase.
  always_comb begin
    dig0_idx = {1'b0, phase_q};
    dig1_idx = {1'b1, phase_q};
    nib0     = act_val_q[{dig0_idx, 2'b00} +: 4];
    nib1     = act_val_q[{dig1_idx, 2'b00} +: 4];
  end

  seg_digit_enc u_enc_grp0 (
    .nibble (nib0),
    .blank  (lz_blank[dig0_idx]),
    .dp     (act_dp_q[dig0_idx]),
    .seg    (seg0_w)
  );

  seg_digit_enc u_enc_grp1 (
    .nibble (nib1),
    .blank  (lz_blank[dig1_idx]),
    .dp     (act_dp_q[dig1_idx]),
    .seg    (seg1_w)
  );

  // Pin values: selects dark during the gap, segment buses track the phase immediately.
  always_comb begin
    cs_d   = (div_cnt_q < BLANK_END) ? 8'h00 : ((8'h01 << dig0_idx) | (8'h01 << dig1_idx));
    seg0_d = seg0_w;
    seg1_d = seg1_w;
  end

  // State and output registers; reset wins over a same-cycle write.
  always_ff @(posedge sys_clk_in) begin
    if (!sys_rst_n) begin
      sh_val_q  <= '0;
      sh_dp_q   <= '0;
      sh_lz_q   <= 1'b0;
      act_val_q <= '0;
      act_dp_q  <= '0;
      act_lz_q  <= 1'b0;
      div_cnt_q <= '0;
      phase_q   <= PHASE_0;
      cs_q      <= '0;
      seg0_q    <= '0;
      seg1_q    <= '0;
    end else begin
      sh_val_q  <= sh_val_d;
      sh_dp_q   <= sh_dp_d;
      sh_lz_q   <= sh_lz_d;
      act_val_q <= act_val_d;
      act_dp_q  <= act_dp_d;
      act_lz_q  <= act_lz_d;
      div_cnt_q <= div_cnt_d;
      phase_q   <= phase_d;
      cs_q      <= cs_d;
      seg0_q    <= seg0_d;
      seg1_q    <= seg1_d;
    end
  end

  assign seg_cs_pin     = cs_q;
  assign seg_data_0_pin = seg0_q;
  assign seg_data_1_pin = seg1_q;

endmodule

// File: tb/tb_io_seg_scan.sv
// Bench for io_seg_scan: a time-based reference model pushes the expected pin
// values for every clock into exp_q; a monitor pops and compares on the falling edge.
module tb_io_seg_scan;

  localparam int SD = 8;
  localparam int BC = 2;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic [7:0]  dp_mask;
  logic        lz_en;
  logic [7:0]  seg_cs_pin;
  logic [0:7]  seg_data_0_pin;
  logic [0:7]  seg_data_1_pin;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  io_seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .sys_clk_in     (clk),
    .sys_rst_n      (rst_n),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .dp_mask        (dp_mask),
    .lz_en          (lz_en),
    .seg_cs_pin     (seg_cs_pin),
    .seg_data_0_pin (seg_data_0_pin),
    .seg_data_1_pin (seg_data_1_pin)
  );

  // ---------------- scoreboard state ----------------
  logic [23:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  // A..G patterns, A in the MSB.
  logic [6:0] seg_tbl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%b want=%b", name, $time, got, want);
    end
  endtask

  // Expected {cs, grp0, grp1} given clocks elapsed since reset and the displayed value.
  function automatic logic [23:0] model_out(input int t, input logic [31:0] v,
                                            input logic [7:0] dp, input logic lz);
    int pos, ph, msd, k;
    logic [7:0] cs;
    logic [7:0] d [2];
    logic [31:0] vv;
    logic [3:0] nib;
    pos = t % SD;
    ph  = (t / SD) % 4;
    msd = -1;
    vv  = v;
    for (int i = 0; i < 8; i++) if (vv[4*i +: 4] != 4'h0) msd = i;
    for (int g = 0; g < 2; g++) begin
      k   = ph + 4 * g;
      nib = vv[4*k +: 4];
      if (lz && k > 0 && k > msd) d[g] = {7'b0000000, dp[k]};
      else                        d[g] = {seg_tbl[nib], dp[k]};
    end
    cs = (pos < BC) ? 8'h00 : ((8'h01 << ph) | (8'h01 << (ph + 4)));
    return {cs, d[0], d[1]};
  endfunction

  // ---------------- reference model ----------------
  int          m_t = 0;
  logic        m_live = 1'b0;
  logic [31:0] m_sh_v, m_act_v;
  logic [7:0]  m_sh_dp, m_act_dp;
  logic        m_sh_lz, m_act_lz;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_t = 0; m_live = 1'b1;
        m_sh_v = '0; m_sh_dp = '0; m_sh_lz = 1'b0;
        m_act_v = '0; m_act_dp = '0; m_act_lz = 1'b0;
        exp_q.push_back(24'h0);
      end else if (m_live) begin
        exp_q.push_back(model_out(m_t, m_act_v, m_act_dp, m_act_lz));
        if (m_t % (4 * SD) == 4 * SD - 1) begin
          m_act_v = m_sh_v; m_act_dp = m_sh_dp; m_act_lz = m_sh_lz;
        end
        if (wr_en) begin
          m_sh_v = wr_data; m_sh_dp = dp_mask; m_sh_lz = lz_en;
        end
        m_t = (m_t + 1) % (4 * SD);
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("seg_cs",   seg_cs_pin,     e[23:16]);
        check("seg_grp0", seg_data_0_pin, e[15:8]);
        check("seg_grp1", seg_data_1_pin, e[7:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [31:0] v, input logic [7:0] dp, input logic lz);
    @(negedge clk);
    wr_en = 1'b1; wr_data = v; dp_mask = dp; lz_en = lz;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Waits (bounded) until the next edge falls in phase ph of the model timeline.
  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while (((m_t / SD) % 4) != ph && n < 64) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s;
    logic [31:0] v;
    rst_n = 1'b0; wr_en = 1'b1; wr_data = 32'hDEAD_BEEF; dp_mask = 8'hFF; lz_en = 1'b1;

    // Reset held 3 clocks with a write pending; it must be dropped.
    repeat (3) @(negedge clk);
    check("rst_cs",   seg_cs_pin,     8'h00);
    check("rst_grp0", seg_data_0_pin, 8'h00);
    check("rst_grp1", seg_data_1_pin, 8'h00);
    rst_n = 1'b1; wr_en = 1'b0;
    check("rel_cs0", seg_cs_pin, 8'h00);
    @(negedge clk);
    check("rel_cs1", seg_cs_pin, 8'h00);
    @(negedge clk);
    check("rel_cs2", seg_cs_pin, 8'h00);
    @(negedge clk);
    check("rel_cs3",   seg_cs_pin,     8'h11);
    check("rel_grp0",  seg_data_0_pin, 8'b1111_1100);
    check("rel_grp1",  seg_data_1_pin, 8'b1111_1100);
    idle(4 * SD);

    // Basic write during phase 2.
    wait_phase(2);
    write(32'h1234_ABCD, 8'h00, 1'b0);
    idle(8 * SD);

    // Leading-zero blanking.
    write(32'h0000_0050, 8'h00, 1'b1);
    idle(8 * SD);
    write(32'h0000_0000, 8'h00, 1'b1);
    idle(8 * SD);

    // Two writes in one frame; the last one wins.
    wait_phase(0);
    write(32'hFFFF_FFFF, 8'h00, 1'b0);
    idle(3);
    write(32'h8888_8888, 8'h81, 1'b0);
    idle(8 * SD);

    // Reset mid-frame with a non-zero display.
    wait_phase(2);
    pulse_reset(1);
    idle(8 * SD);

    // Randomized writes with varying leading zeros, lz and dp, occasional resets.
    for (int i = 0; i < 150; i++) begin
      idle($urandom_range(0, 24));
      s = $urandom_range(0, 8);
      v = $urandom;
      v = (s == 8) ? 32'h0 : (v >> (4 * s));
      if ($urandom_range(0, 19) == 0) begin
        @(negedge clk);
        rst_n = 1'b0; wr_en = 1'b1; wr_data = $urandom; dp_mask = 8'($urandom);
        @(negedge clk);
        rst_n = 1'b1; wr_en = 1'b0;
      end else begin
        write(v, 8'($urandom), 1'($urandom_range(0, 1)));
      end
    end
    idle(8 * SD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
